// File: rtl/jk_pkg.sv
// Shared JK flip-flop action encodings and the next-state function.
// Both the ffjk_cell sub-module and the counter testbench model use this package.
package jk_pkg;

   // bit1 = J, bit0 = K
   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_RST  = 2'b01,
      JK_SET  = 2'b10,
      JK_TGL  = 2'b11
   } jk_action_e;

   function automatic logic jk_next(input logic q, input logic j, input logic k);
      logic r_n;
      r_n = q;
      case (jk_action_e'({j, k}))
         JK_HOLD: r_n = q;
         JK_RST:  r_n = 1'b0;
         JK_SET:  r_n = 1'b1;
         JK_TGL:  r_n = ~q;
         default: r_n = q;
      endcase
      return r_n;
   endfunction

endpackage

// File: rtl/ffjk_cell.sv
// One JK flip-flop bit with synchronous active-high reset and a clock enable.
module ffjk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic j,
   input  logic k,
   output logic q
);

   logic r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= 1'b0;
      end else if (enable) begin
         r_q <= jk_next(r_q, j, k);
      end
   end

   assign q = r_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous up/down modulo-MODULUS counter built from ffjk_cell bits, cascadable via enable/tc.
// Optional parallel load (load, d ports) is compiled in when JK_CNT_LOAD_EN is defined.
module jk_sync_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             up_dn,
`ifdef JK_CNT_LOAD_EN
   input  logic             load,
   input  logic [WIDTH-1:0] d,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_err
      $error("jk_sync_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
   end

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

   logic             w_load;
   logic [WIDTH-1:0] w_d;
   logic             w_wrap_up;
   logic             w_wrap_dn;
   logic             w_force;
   logic [WIDTH-1:0] w_target;
   logic [WIDTH-1:0] w_tgl;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic             w_cell_en;

`ifdef JK_CNT_LOAD_EN
   assign w_load = load;
   assign w_d    = d;
`else
   assign w_load = 1'b0;
   assign w_d    = '0;
`endif

   // Out-of-range values (only reachable by load) fall into the wrap cases.
   assign w_wrap_up = (q >= MAX_VAL);
   assign w_wrap_dn = (q == '0) || ({1'b0, q} >= MOD_EXT);

   always_comb begin
      w_force  = 1'b0;
      w_target = '0;
      if (clear) begin
         w_force  = 1'b1;
         w_target = '0;
      end else if (w_load) begin
         w_force  = 1'b1;
         w_target = w_d;
      end else if (enable) begin
         if (up_dn && w_wrap_up) begin
            w_force  = 1'b1;
            w_target = '0;
         end else if (!up_dn && w_wrap_dn) begin
            w_force  = 1'b1;
            w_target = MAX_VAL;
         end
      end
   end

   // Ripple toggle chain: a bit flips when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      logic chain;
      chain = 1'b1;
      w_tgl = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_tgl[i] = chain;
         chain    = chain & (up_dn ? q[i] : ~q[i]);
      end
   end

   always_comb begin
      w_j = '0;
      w_k = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_force) begin
            w_j[i] = w_target[i];
            w_k[i] = ~w_target[i];
         end else if (enable) begin
            w_j[i] = w_tgl[i];
            w_k[i] = w_tgl[i];
         end
      end
   end

   assign w_cell_en = clear | w_load | enable;

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      ffjk_cell u_cell (
         .clk    (clk),
         .reset  (reset),
         .enable (w_cell_en),
         .j      (w_j[g]),
         .k      (w_k[g]),
         .q      (q[g])
      );
   end

   assign tc = enable & (up_dn ? (q == MAX_VAL) : (q == '0));

endmodule
